// File: rtl/vga_timing_pkg.sv
// Shared video timing definitions: standard mode constants, the timing record
// and helpers for deriving line/frame totals and raster counter widths.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t TIMING_1080P60 = '{
    h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36
  };

  localparam vga_timing_t TIMING_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // A single-position raster still needs a one-bit counter.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Pixel clock-enable divider: one strobe every CLK_DIV enabled system clocks.
module vga_pix_ce_div #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_r;

  // Divider phase: advances while running, holds when stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= {DW{1'b0}};
    end else if (en) begin
      if (div_r == DIV_LAST) begin
        div_r <= {DW{1'b0}};
      end else begin
        div_r <= div_r + DIV_ONE;
      end
    end
  end

  // Gated by reset so a CLK_DIV of 1 still reads 0 while held in reset.
  assign pix_ce = en && !reset && (div_r == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with registered sync, data-enable and
// colour outputs, upstream pixel request and sticky underflow detection.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = int'(TIMING_1080P60.h_active),
  parameter int H_FP     = int'(TIMING_1080P60.h_fp),
  parameter int H_SYNC   = int'(TIMING_1080P60.h_sync),
  parameter int H_BP     = int'(TIMING_1080P60.h_bp),
  parameter int V_ACTIVE = int'(TIMING_1080P60.v_active),
  parameter int V_FP     = int'(TIMING_1080P60.v_fp),
  parameter int V_SYNC   = int'(TIMING_1080P60.v_sync),
  parameter int V_BP     = int'(TIMING_1080P60.v_bp),
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1,
  parameter int CLK_DIV  = 20,
  parameter int CW       = 8,
  parameter logic [3*CW-1:0] BG_COLOR = {(3*CW){1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [3*CW-1:0]     rgb_in,
  input  logic                rgb_valid,
  output logic                pix_ce,
  output logic                pix_req,
  output logic [cnt_width(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] pix_x,
  output logic [cnt_width(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] pix_y,
  output logic [CW-1:0]       red,
  output logic [CW-1:0]       green,
  output logic [CW-1:0]       blue,
  output logic                de,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start,
  output logic                line_start,
  output logic                underflow
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int XW = cnt_width(H_TOTAL);
  localparam int YW = cnt_width(V_TOTAL);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  int               x_int_s;
  int               y_int_s;
  logic             hs_s;
  logic             vs_s;
  logic [3*CW-1:0]  rgb_s;

  vga_pix_ce_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .pix_ce (pix_ce)
  );

  // Integer views keep the decode comparisons free of counter-width truncation.
  assign x_int_s = int'(pix_x);
  assign y_int_s = int'(pix_y);
  assign pix_req = (x_int_s < H_ACTIVE) && (y_int_s < V_ACTIVE);

  // Raster position advances once per pixel strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x <= {XW{1'b0}};
      pix_y <= {YW{1'b0}};
    end else if (pix_ce) begin
      if (x_int_s == H_TOTAL - 1) begin
        pix_x <= {XW{1'b0}};
        if (y_int_s == V_TOTAL - 1) begin
          pix_y <= {YW{1'b0}};
        end else begin
          pix_y <= pix_y + Y_ONE;
        end
      end else begin
        pix_x <= pix_x + X_ONE;
      end
    end
  end

  // Sync decode and colour selection for the current raster position.
  always_comb begin
    hs_s  = ~HS_POL;
    vs_s  = ~VS_POL;
    rgb_s = {(3*CW){1'b0}};
    if ((x_int_s >= H_SYNC_BEG) && (x_int_s < H_SYNC_END)) begin
      hs_s = HS_POL;
    end else begin
      hs_s = ~HS_POL;
    end
    if ((y_int_s >= V_SYNC_BEG) && (y_int_s < V_SYNC_END)) begin
      vs_s = VS_POL;
    end else begin
      vs_s = ~VS_POL;
    end
    if (pix_req && rgb_valid) begin
      rgb_s = rgb_in;
    end else if (pix_req) begin
      rgb_s = BG_COLOR;
    end else begin
      rgb_s = {(3*CW){1'b0}};
    end
  end

  // Output stage: captures the pre-increment position on each strobe; the
  // start pulses last exactly one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      red         <= {CW{1'b0}};
      green       <= {CW{1'b0}};
      blue        <= {CW{1'b0}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (pix_ce) begin
      de                 <= pix_req;
      hsync              <= hs_s;
      vsync              <= vs_s;
      {red, green, blue} <= rgb_s;
      line_start         <= (x_int_s == 0);
      frame_start        <= (x_int_s == 0) && (y_int_s == 0);
      underflow          <= underflow || (pix_req && !rgb_valid);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator and pixel output stage. It is the next generation of the team's fixed 1080p VGA controller. A single system clock drives it, and a clock-enable pixel strobe replaces the divided clock. Every porch, sync width, sync polarity and colour width is a parameter. It adds upstream pixel-request coordinates, frame and line start pulses, a run/stop control, and underflow detection with a background colour. It sits between the frame-buffer or text-extraction pipeline and the DAC/HDMI transmitter pins.

## Interface
- `H_ACTIVE`, 1920, visible pixels per line
- `H_FP`, 88, horizontal front porch (pixels)
- `H_SYNC`, 44, horizontal sync width
- `H_BP`, 148, horizontal back porch
- `V_ACTIVE`, 1080, visible lines per frame
- `V_FP`, 4, vertical front porch (lines)
- `V_SYNC`, 5, vertical sync width
- `V_BP`, 36, vertical back porch
- `HS_POL`, 1, hsync level while in sync (1 = active-high)
- `VS_POL`, 1, vsync level while in sync
- `CLK_DIV`, 20, clk cycles per pixel; must be ≥1; 1 = every cycle
- `CW`, 8, bits per colour channel
- `BG_COLOR`, 0, {R,G,B} value (3·CW bits) driven on underflow
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: run; when low, the divider and counters hold.
- `rgb_in` in 3·CW: {R,G,B} for the pixel at `pix_x`/`pix_y`.
- `rgb_valid` in 1: `rgb_in` holds valid data.
- `pix_ce` out 1: one-clk strobe per pixel period.
- `pix_req` out 1: the current counter position is active video.
- `pix_x` out clog2(H_TOTAL): horizontal counter.
- `pix_y` out clog2(V_TOTAL): vertical counter.
- `red` / `green` / `blue` out CW each: registered colour output.
- `de` out 1: data enable, aligned with the colour outputs.
- `hsync` / `vsync` out 1: registered sync outputs.
- `frame_start` out 1: one-clk pulse.
- `line_start` out 1: one-clk pulse.
- `underflow` out 1: sticky underflow flag; cleared only by reset.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active [0, H_ACTIVE), front porch, sync, back porch. The vertical order matches, counted in lines.
- Divider: counts 0..CLK_DIV-1 on `clk` while `en`=1. `pix_ce`=1 on the clk where the divider equals CLK_DIV-1, then the divider wraps to 0. With `en`=0 the divider holds and `pix_ce`=0.
- Counters (`pix_x`, `pix_y`) advance only on `pix_ce`:
  - `pix_x` wraps at H_TOTAL-1 → 0.
  - `pix_y` increments on the `pix_x` wrap and wraps at V_TOTAL-1 → 0.
- `pix_req` is combinational: (`pix_x` < H_ACTIVE) && (`pix_y` < V_ACTIVE).
- Output stage updates only on `pix_ce`, sampling the pre-increment counters:
  - `de` ← `pix_req`
  - `hsync` ← HS_POL when `pix_x` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL
  - `vsync` uses the same rule on `pix_y` with V parameters
  - colour ← `rgb_in` if `pix_req`&&`rgb_valid`; BG_COLOR if `pix_req`&&!`rgb_valid`; 0 if !`pix_req`
- Underflow: `pix_req`&&!`rgb_valid` on a `pix_ce` sets `underflow`. It stays set until reset.
- `line_start`: 1 for one clk on the `pix_ce` where `pix_x`==0. `frame_start` additionally requires `pix_y`==0. Both are registered together with the output stage.
- `en` falling mid-line: all state and outputs hold, with no blanking forced. `en` rising resumes from the held position.

## Timing
- Reset values:
  - divider, `pix_x`, `pix_y`: 0
  - `de`, colour outputs, `frame_start`, `line_start`, `underflow`, `pix_ce`: 0
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL (inactive)
- The first `pix_ce` occurs CLK_DIV clks after reset release (with `en`=1).
- Latency: outputs reflect the counter position from one `pix_ce` earlier and change on the clk after the strobe.
- Upstream timing: upstream has CLK_DIV clks to present `rgb_in` for (`pix_x`, `pix_y`). Sampling occurs only on the `pix_ce` clk.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clks exactly.
- Reset mid-frame: everything returns asynchronously to the reset values. The first frame after release begins at (0,0) and produces `frame_start`.

## Structure
- Package `vga_timing_pkg` holds:
  - default 1080p60 and 640x480 timing constants
  - a `vga_timing_t` struct (h/v active, fp, sync, bp)
  - a function computing total and counter width
- Sub-module `vga_pix_ce_div`: CLK_DIV divider with `en`, producing `pix_ce`.
- Counters, sync decode and the output register live in the top module.

## Test plan
Small config used throughout: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=2, CW=4, HS_POL=0, VS_POL=1, BG_COLOR=12'hF00.

- **Reset/period:** assert `reset` for 3 clks, then release with `en`=1 → `pix_ce` every 2nd clk; `frame_start` every 224 clks; `hsync`=1 and `vsync`=0 during reset.
- **Sync placement:** free-run one frame → `hsync`=0 for exactly 3 pixels (x = 10..12 sampled); `vsync`=1 for lines 5..6; `de` high for 8×4 pixels per frame.
- **Data path:** set `rgb_in` = {pix_x, pix_y, 4'h5}, `rgb_valid`=1 → each active pixel outputs matching values one `pix_ce` later; blanking outputs 0.
- **Underflow:** drop `rgb_valid` for pixel (3,1) → output 12'hF00 for that pixel only; `underflow` rises and stays set through later frames.
- **Stall:** deassert `en` for 7 clks mid-line → `pix_ce` absent; `pix_x`, `pix_y` and all outputs frozen; sequence resumes with no pixel skipped or duplicated.
- **Mid-frame reset:** assert `reset` at (5,2) → `hsync`/`vsync` go inactive immediately; after release, `frame_start` occurs before any `de`.
